// File: rtl/systolic_drain_if.sv
// Valid/ready write port carrying one drained accumulator element and its
// row-major index toward the result memory or host writer.
interface systolic_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (output out_valid, output out_data, output out_addr, input out_ready);
  modport slave  (input out_valid, input out_data, input out_addr, output out_ready);
endinterface

// File: rtl/systolic_drain.sv
// Result drain for the systolic MAC array: snapshots all N*M accumulators on
// load and streams them out row-major, one element per valid/ready handshake.
module systolic_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 3,
  parameter int M          = 3,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [N*M*DATA_WIDTH-1:0]    C_flat,
  systolic_drain_if.master             wr,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int TOTAL = N * M;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   index;
  logic [ADDR_WIDTH-1:0]   next_index;
  logic [DATA_WIDTH-1:0]   buffer [TOTAL];
  logic                    capture;

  // A load is honoured in IDLE and in the DONE cycle; in DRAIN it only flags overrun.
  assign capture    = load && (state != DRAIN);
  assign next_index = index + 1'b1;

  // Snapshot buffer needs no reset: its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < TOTAL; k++) begin
        buffer[k] <= C_flat[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      index        <= '0;
      wr.out_valid <= 1'b0;
      wr.out_data  <= '0;
      wr.out_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load) begin
            state        <= DRAIN;
            index        <= '0;
            wr.out_valid <= 1'b1;
            wr.out_addr  <= '0;
            wr.out_data  <= C_flat[DATA_WIDTH-1:0];
            busy         <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (load) begin
            overrun <= 1'b1;
          end
          if (wr.out_ready) begin
            if (index == LAST) begin
              state        <= DONE;
              wr.out_valid <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              // Present the next element directly from the snapshot so outputs stay registered.
              index       <= next_index;
              wr.out_addr <= next_index;
              wr.out_data <= buffer[next_index];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_drain.md
# systolic_drain

Result drain for the 3x3 systolic MAC array. When the array control pulses `load`, the block snapshots all N*M accumulator outputs in one cycle, then streams them out one per handshake over a valid/ready write port in row-major order with an element address. It is the output-side counterpart of the array's A/B read-enable feed and sits between the array and the result memory or host writer.

## Interface
- DATA_WIDTH, 32, width of one C element.
- N, 3, array rows.
- M, 3, array columns.
- ADDR_WIDTH, 4, width of out_addr; must satisfy 2^ADDR_WIDTH >= N*M.

- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  capture strobe from array control; one-cycle pulse when C values are valid.
- C_flat  input  N*M*DATA_WIDTH  packed accumulators; element k = M*i+j occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  out_data/out_addr hold a pending element.
- out_ready  input  1  downstream accepts the element this cycle.
- out_data  output  DATA_WIDTH  current element value.
- out_addr  output  ADDR_WIDTH  current element index k.
- busy  output  1  high while in DRAIN.
- done  output  1  one-cycle pulse after the last element is accepted.
- overrun  output  1  sticky flag: a load arrived while busy.

## Operation
- States: IDLE, DRAIN, DONE.
- IDLE: out_valid=0. On load=1, capture all N*M elements of C_flat into an internal buffer, set index=0, and go to DRAIN.
- DRAIN: out_valid=1, out_addr=index, out_data=buffer[index].
  - Handshake occurs on out_valid && out_ready at a rising edge.
  - On a handshake with index < N*M-1: index increments.
  - On a handshake with index = N*M-1: go to DONE.
  - With out_ready=0: hold index; out_data and out_addr stay stable.
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE.
  - A load sampled in DONE is accepted exactly as in IDLE (capture, index=0, next state DRAIN).
  - done still pulses in that cycle.
- Load while in DRAIN: ignored. The buffer and index are unchanged, and overrun is set to 1. overrun clears only on reset.
- Data is passed through unmodified. There is no arithmetic on C; out_addr is the index zero-extended to ADDR_WIDTH.
- Later changes on C_flat have no effect until the next accepted load.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately and index=0.
  - out_valid=0, out_data=0, out_addr=0, busy=0, done=0, overrun=0.
  - Buffer contents are don't-care.
- Reset mid-DRAIN aborts the drain; no done pulse is issued.
- Load accepted at edge t: busy=1 and out_valid=1 with addr 0 from cycle t+1.
- With out_ready held high: elements 0..N*M-1 go out on consecutive cycles t+1..t+N*M. done=1 in cycle t+N*M+1, and IDLE follows at t+N*M+2.
- Minimum load-to-load spacing without overrun is N*M+1 cycles, since a load in the DONE cycle is accepted.
- out_valid never drops in DRAIN without a completed handshake on the last element.
- done and out_valid are never high together.
- busy equals (state==DRAIN), registered.

## Test plan
- Reset, then load with C_flat holding element k = 100+k and out_ready=1 -> out_addr 0..8 with out_data 100..108 on 9 consecutive cycles; done high exactly once, one cycle after addr 8; overrun=0.
- Same capture, out_ready toggled 1,0,0,1,... -> each element presented until accepted, no skips or duplicates; data and addr stable while out_ready=0; total 9 handshakes.
- Change C_flat to all 0xFFFFFFFF one cycle after load -> drained values still 100..108.
- Second load pulsed at element 4 of a drain -> drain continues with the original values, overrun=1 stays set; a load in the DONE cycle -> new capture, addr 0 appears the next cycle, overrun unchanged.
- rst driven low at element 5, between clock edges -> out_valid, busy, overrun, out_data, out_addr all 0 immediately; no done pulse; a fresh load after release drains from addr 0.
